// File: rtl/genius_pkg.sv
// Shared clock-generator constants: default frequencies and the derived prescaler sizing.
package genius_pkg;

   function automatic int unsigned presc_div_calc(input int unsigned clk_hz,
                                                  input int unsigned cl3_hz);
      if (cl3_hz == 0) return 0;
      return clk_hz / (2 * cl3_hz);
   endfunction

   // Never narrower than one bit, even for degenerate divide ratios.
   function automatic int unsigned presc_w_calc(input int unsigned div);
      if (div <= 2) return 1;
      return $clog2(div);
   endfunction

   localparam int unsigned CLK_FREQ_HZ = 50_000_000;
   localparam int unsigned CL3_FREQ_HZ = 4;
   localparam int unsigned PRESC_DIV   = presc_div_calc(CLK_FREQ_HZ, CL3_FREQ_HZ);
   localparam int unsigned PRESC_W     = presc_w_calc(PRESC_DIV);

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..Div-1 counter; step_o marks the enabled cycle that holds Div-1.
module tick_prescaler
   import genius_pkg::*;
#(
   parameter int unsigned Div = PRESC_DIV
) (
   input  logic CLK_i,
   input  logic RST_n_i,
   input  logic en_i,
   input  logic clr_i,
   output logic step_o
);

   localparam int unsigned W = presc_w_calc(Div);

   logic [W-1:0] cnt_q, cnt_d;
   logic         last;

   assign last   = (cnt_q == W'(Div - 1));
   assign step_o = en_i & ~clr_i & last;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = last ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK_i or negedge RST_n_i) begin
      if (!RST_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/clk_gen_4x.sv
// Four phase-aligned game-level square waves from one prescaled 4-bit counter,
// plus registered one-cycle rise ticks for each.
module clk_gen_4x
   import genius_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = genius_pkg::CLK_FREQ_HZ,
   parameter int unsigned CL3_FREQ_HZ = genius_pkg::CL3_FREQ_HZ
) (
   input  logic       CLK_i,
   input  logic       RST_n_i,
   input  logic       en_i,
   input  logic       clr_i,
   output logic       CL0_o,
   output logic       CL1_o,
   output logic       CL2_o,
   output logic       CL3_o,
   output logic [3:0] tick_o
);

   localparam int unsigned PrescDiv = presc_div_calc(CLK_FREQ_HZ, CL3_FREQ_HZ);

   if (CL3_FREQ_HZ == 0 || (CLK_FREQ_HZ % (2 * CL3_FREQ_HZ)) != 0 || PrescDiv < 2) begin : g_cfg_err
      $error("clk_gen_4x: CLK_FREQ_HZ/(2*CL3_FREQ_HZ) must be an integer >= 2");
   end

   logic       step;
   logic [3:0] div_q, div_d;
   logic [3:0] tick_q, tick_d;
   logic [3:0] rise;

   tick_prescaler #(
      .Div (PrescDiv)
   ) u_presc (
      .CLK_i   (CLK_i),
      .RST_n_i (RST_n_i),
      .en_i    (en_i),
      .clr_i   (clr_i),
      .step_o  (step)
   );

   // tick bit k belongs to CLk_o, which is div bit 3-k, hence the reversal.
   always_comb begin
      div_d  = div_q;
      tick_d = '0;
      rise   = '0;
      if (clr_i) begin
         div_d = '0;
      end else if (step) begin
         div_d  = div_q + 4'd1;
         rise   = div_d & ~div_q;
         tick_d = {rise[0], rise[1], rise[2], rise[3]};
      end
   end

   always_ff @(posedge CLK_i or negedge RST_n_i) begin
      if (!RST_n_i) begin
         div_q  <= '0;
         tick_q <= '0;
      end else begin
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

   assign CL3_o  = div_q[0];
   assign CL2_o  = div_q[1];
   assign CL1_o  = div_q[2];
   assign CL0_o  = div_q[3];
   assign tick_o = tick_q;

endmodule

// File: tb/tb_clk_gen_4x.sv
// Directed plus randomized bench for clk_gen_4x against an enabled-cycle-count model.
module tb_clk_gen_4x;

   localparam int unsigned PD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic       cl0, cl1, cl2, cl3;
   logic [3:0] tick;
   logic [3:0] outs;

   int checks   = 0;
   int failures = 0;
   // Model: n counts enabled cycles since the last restart; everything else is derived.
   int n        = 0;
   bit last_inc = 1'b0;

   clk_gen_4x #(
      .CLK_FREQ_HZ (32),
      .CL3_FREQ_HZ (4)
   ) dut (
      .CLK_i   (clk),
      .RST_n_i (rst_n),
      .en_i    (en),
      .clr_i   (clr),
      .CL0_o   (cl0),
      .CL1_o   (cl1),
      .CL2_o   (cl2),
      .CL3_o   (cl3),
      .tick_o  (tick)
   );

   always #5 clk = ~clk;

   assign outs = {cl0, cl1, cl2, cl3};

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [3:0] div_at(input int m);
      return 4'((m / PD) % 16);
   endfunction

   function automatic logic [3:0] exp_tick();
      logic [3:0] r;
      if (!last_inc || (n % PD) != 0) return 4'b0000;
      r = div_at(n) & ~div_at(n - 1);
      return {r[0], r[1], r[2], r[3]};
   endfunction

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      if (clr) begin
         n = 0;
         last_inc = 1'b0;
      end else if (en) begin
         n++;
         last_inc = 1'b1;
      end else begin
         last_inc = 1'b0;
      end
      @(negedge clk);
      check("outs", int'(outs), int'(div_at(n)));
      check("tick", int'(tick), int'(exp_tick()));
   endtask

   task automatic rise_latency(output int lat);
      lat = 0;
      do begin
         cyc();
         lat++;
      end while (!cl3 && lat < 20);
   endtask

   initial begin
      int         first;
      int         lat;
      int         guard;
      int         cnt [4];
      logic [3:0] hold;
      logic [3:0] d;

      rst_n = 1'b0;
      en    = 1'b0;
      clr   = 1'b0;
      #13;
      check("reset_outs", int'(outs), 0);
      check("reset_tick", int'(tick), 0);

      // Release and run 64 enabled cycles.
      @(negedge clk);
      rst_n = 1'b1;
      en    = 1'b1;
      n = 0;
      last_inc = 1'b0;
      first = -1;
      for (int k = 0; k < 4; k++) cnt[k] = 0;
      for (int i = 1; i <= 64; i++) begin
         cyc();
         if (cl3 && first < 0) first = i;
         for (int k = 0; k < 4; k++) cnt[k] += int'(tick[k]);
      end
      check("first_cl3_rise", first, 4);
      check("ticks_cl3", cnt[3], 8);
      check("ticks_cl2", cnt[2], 4);
      check("ticks_cl1", cnt[1], 2);
      check("ticks_cl0", cnt[0], 1);

      // Freeze mid-period.
      cyc();
      cyc();
      hold = outs;
      en = 1'b0;
      repeat (10) begin
         cyc();
         check("freeze_outs", int'(outs), int'(hold));
      end
      en = 1'b1;
      repeat (6) cyc();

      // Clear while the count sits at 4'hB.
      guard = 0;
      while (div_at(n) != 4'hB && guard < 200) begin
         cyc();
         guard++;
      end
      check("reach_b", int'(outs), 11);
      clr = 1'b1;
      cyc();
      check("clr_outs", int'(outs), 0);
      check("clr_tick", int'(tick), 0);
      clr = 1'b0;
      rise_latency(lat);
      check("clr_rise_latency", lat, 4);

      // 7->8 and F->0 transitions.
      guard = 0;
      while (!(last_inc && (n % PD) == 0 && div_at(n) == 4'h8) && guard < 200) begin
         cyc();
         guard++;
      end
      check("tick_7to8", int'(tick), 1);
      guard = 0;
      do begin
         cyc();
         guard++;
      end while (!(last_inc && (n % PD) == 0 && div_at(n) == 4'h0) && guard < 200);
      check("wrap_outs", int'(outs), 0);
      check("wrap_tick", int'(tick), 0);

      // Asynchronous reset between edges while CL0 is high, mid-prescaler.
      guard = 0;
      do begin
         cyc();
         d = div_at(n);
         guard++;
      end while (!(d[3] && (n % PD) == 2) && guard < 400);
      check("pre_rst_cl0", int'(cl0), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_outs", int'(outs), 0);
      check("async_rst_tick", int'(tick), 0);
      n = 0;
      last_inc = 1'b0;
      @(negedge clk);
      check("rst_hold_outs", int'(outs), 0);
      rst_n = 1'b1;
      rise_latency(lat);
      check("rst_rise_latency", lat, 4);

      // Randomized enable/clear traffic against the model.
      repeat (400) begin
         en  = ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 31) == 0);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
